// File: rtl/sample_fifo_pkg.sv
// Default geometry for the sample FIFO.
// Instances still override these through their own module parameters.
package sample_fifo_pkg;
   localparam int unsigned DEF_DWIDTH       = 32;
   localparam int unsigned DEF_DEPTH        = 16;
   localparam int unsigned DEF_DEPTH_LOG    = 4;
   localparam int unsigned DEF_AFULL_THRESH = 12;
endpackage

// File: rtl/sample_fifo_ram.sv
// Simple dual-port storage with a synchronous write and an asynchronous read.
// The array has no reset, so it can map onto distributed RAM.
module fifo_ram
#(
   parameter int unsigned DWIDTH    = 32,
   parameter int unsigned DEPTH_LOG = 4
)
(
   input  logic                 clk,
   input  logic                 we,
   input  logic [DEPTH_LOG-1:0] waddr,
   input  logic [DWIDTH-1:0]    wdata,
   input  logic [DEPTH_LOG-1:0] raddr,
   output logic [DWIDTH-1:0]    rdata
);
   logic [DWIDTH-1:0] mem [2**DEPTH_LOG];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/sample_fifo.sv
// First-word-fall-through sample FIFO with passive req/ack channels on both sides.
// The registered occupancy counter is the only source for every status flag.
module sample_fifo
   import sample_fifo_pkg::*;
#(
   parameter int unsigned DWIDTH       = DEF_DWIDTH,
   parameter int unsigned DEPTH        = DEF_DEPTH,
   parameter int unsigned DEPTH_LOG    = DEF_DEPTH_LOG,
   parameter int unsigned AFULL_THRESH = DEF_AFULL_THRESH
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_req,
   output logic                 in_ack,
   input  logic [DWIDTH-1:0]    in_data,
   output logic                 out_req,
   input  logic                 out_ack,
   output logic [DWIDTH-1:0]    out_data,
   output logic                 empty,
   output logic                 full,
   output logic                 almost_full,
   output logic [DEPTH_LOG:0]   level
);
   localparam logic [DEPTH_LOG:0] FULL_LVL  = DEPTH[DEPTH_LOG:0];
   localparam logic [DEPTH_LOG:0] AFULL_LVL = AFULL_THRESH[DEPTH_LOG:0];

   logic [DEPTH_LOG-1:0] wr_ptr;
   logic [DEPTH_LOG-1:0] rd_ptr;
   logic [DEPTH_LOG:0]   level_q;
   logic [DWIDTH-1:0]    rd_data;
   logic                 push;
   logic                 pop;

   assign push = in_req && in_ack;
   assign pop  = out_req && out_ack;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   fifo_ram #(
      .DWIDTH    (DWIDTH),
      .DEPTH_LOG (DEPTH_LOG)
   ) u_ram (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (in_data),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

   assign level       = level_q;
   assign empty       = (level_q == '0);
   assign full        = (level_q == FULL_LVL);
   assign almost_full = (level_q >= AFULL_LVL);
   assign out_req     = !empty;
   // The unreset array is masked while empty, so out_data reads 0 after reset.
   assign out_data    = empty ? '0 : rd_data;
   assign in_ack      = !full && !rst;
endmodule

// File: tb/tb_sample_fifo.sv
// Directed bench for sample_fifo: reset, fill, drain, wrap, full-with-pop and mid-run reset.
module tb_sample_fifo;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_req;
   logic        in_ack;
   logic [31:0] in_data;
   logic        out_req;
   logic        out_ack;
   logic [31:0] out_data;
   logic        empty;
   logic        full;
   logic        almost_full;
   logic [4:0]  level;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   logic [31:0] model_q [$];
   logic [31:0] exp_word;

   sample_fifo #(
      .DWIDTH       (32),
      .DEPTH        (16),
      .DEPTH_LOG    (4),
      .AFULL_THRESH (12)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_req      (in_req),
      .in_ack      (in_ack),
      .in_data     (in_data),
      .out_req     (out_req),
      .out_ack     (out_ack),
      .out_data    (out_data),
      .empty       (empty),
      .full        (full),
      .almost_full (almost_full),
      .level       (level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle 1 ns past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst     = 1'b1;
      in_req  = 1'b1;
      in_data = 32'hDEAD_BEEF;
      out_ack = 1'b0;
      repeat (10) step();
      check("rst_in_ack",  {31'b0, in_ack},  32'd0);
      check("rst_level",   {27'b0, level},   32'd0);
      check("rst_empty",   {31'b0, empty},   32'd1);
      check("rst_out_req", {31'b0, out_req}, 32'd0);
      check("rst_out_data", out_data,        32'd0);
      check("rst_full",    {31'b0, full},    32'd0);
      check("rst_afull",   {31'b0, almost_full}, 32'd0);
      in_req = 1'b0;
      rst    = 1'b0;
      #1;
      check("rel_in_ack", {31'b0, in_ack}, 32'd1);

      // Fill 1..16 back-to-back.
      for (int i = 1; i <= 16; i++) begin
         in_req  = 1'b1;
         in_data = i;
         step();
         check("fill_level",  {27'b0, level},       i);
         check("fill_afull",  {31'b0, almost_full}, (i >= 12) ? 32'd1 : 32'd0);
         check("fill_full",   {31'b0, full},        (i == 16) ? 32'd1 : 32'd0);
         check("fill_in_ack", {31'b0, in_ack},      (i < 16)  ? 32'd1 : 32'd0);
         check("fill_head",   out_data,             32'd1);
      end
      in_data = 32'h11;
      step();
      check("over_level", {27'b0, level}, 32'd16);
      check("over_full",  {31'b0, full},  32'd1);
      in_req = 1'b0;

      // Drain in order.
      out_ack = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         check("drain_data",    out_data,          i);
         check("drain_out_req", {31'b0, out_req},  32'd1);
         step();
         check("drain_level",   {27'b0, level},    16 - i);
      end
      out_ack = 1'b0;
      check("drain_empty",   {31'b0, empty},   32'd1);
      check("drain_out_req0", {31'b0, out_req}, 32'd0);

      // Prime to level 5, then push and pop together across the pointer wrap.
      for (int k = 0; k < 5; k++) begin
         in_req  = 1'b1;
         in_data = 32'h100 + k;
         model_q.push_back(in_data);
         step();
      end
      check("sim_prime_level", {27'b0, level}, 32'd5);
      out_ack = 1'b1;
      for (int c = 0; c < 40; c++) begin
         in_data = 32'h200 + c;
         check("sim_data", out_data, model_q[0]);
         exp_word = model_q.pop_front();
         model_q.push_back(in_data);
         step();
         check("sim_level", {27'b0, level}, 32'd5);
      end
      out_ack = 1'b0;

      // Top up to full.
      for (int k = 0; k < 11; k++) begin
         in_data = 32'h300 + k;
         model_q.push_back(in_data);
         step();
      end
      check("top_level", {27'b0, level}, 32'd16);

      // Full: pop and offered push in the same cycle; push lands next cycle.
      in_data = 32'hABCD_0001;
      out_ack = 1'b1;
      check("fp_in_ack0", {31'b0, in_ack}, 32'd0);
      check("fp_head",    out_data,        model_q[0]);
      exp_word = model_q.pop_front();
      step();
      check("fp_level15", {27'b0, level}, 32'd15);
      check("fp_in_ack1", {31'b0, in_ack}, 32'd1);
      check("fp_next",    out_data,        model_q[0]);
      out_ack = 1'b0;
      model_q.push_back(in_data);
      step();
      in_req = 1'b0;
      check("fp_level16", {27'b0, level}, 32'd16);

      // Pop 9 to reach level 7, checking order as we go.
      out_ack = 1'b1;
      for (int k = 0; k < 9; k++) begin
         check("pre_rst_data", out_data, model_q[0]);
         exp_word = model_q.pop_front();
         step();
      end
      out_ack = 1'b0;
      check("pre_rst_level", {27'b0, level}, 32'd7);

      // Asynchronous reset pulse mid-operation.
      rst = 1'b1;
      #1;
      check("mrst_level",    {27'b0, level},   32'd0);
      check("mrst_empty",    {31'b0, empty},   32'd1);
      check("mrst_out_req",  {31'b0, out_req}, 32'd0);
      check("mrst_in_ack",   {31'b0, in_ack},  32'd0);
      check("mrst_out_data", out_data,         32'd0);
      step();
      rst = 1'b0;
      #1;
      in_req  = 1'b1;
      in_data = 32'hCAFE_F00D;
      step();
      in_req = 1'b0;
      check("post_out_req", {31'b0, out_req}, 32'd1);
      check("post_data",    out_data,         32'hCAFE_F00D);
      check("post_level",   {27'b0, level},   32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
